// File: rtl/mod_n_updown_counter_if.sv
// Bus bundle for the modulo-N up/down counter: control and load inputs plus
// the registered count, terminal-count and illegal-load outputs.
interface mod_n_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             upd;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             load_err;

    // master drives the controls, slave is the counter itself
    modport master (
        output enable, load, data_in, upd,
        input  count, tc, load_err
    );

    modport slave (
        input  enable, load, data_in, upd,
        output count, tc, load_err
    );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Parametrised modulo-N up/down counter with count enable, wrap or saturate
// at the range ends, a one-cycle terminal-count pulse and illegal-load detection.
module mod_n_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 12,
    parameter bit SATURATE = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    mod_n_updown_counter_if.slave  bus
);

    // A modulus outside 2..2**WIDTH cannot be represented, so refuse to build
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MODULUS_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_next;
    logic             tc_q;
    logic             tc_next;
    logic             load_err_q;
    logic             load_err_next;
    logic             load_legal;

    // One extra bit so MODULUS == 2**WIDTH still compares correctly
    assign load_legal = ({1'b0, bus.data_in} < MODULUS_EXT);

    always_comb begin
        count_next    = count_q;
        tc_next       = 1'b0;
        load_err_next = 1'b0;

        if (bus.load) begin
            if (load_legal) begin
                count_next = bus.data_in;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (bus.enable) begin
            if (bus.upd) begin
                // Range end is tested before incrementing, so no overflow reaches count
                if (count_q == MAX_COUNT) begin
                    count_next = SATURATE ? MAX_COUNT : '0;
                    tc_next    = 1'b1;
                end else begin
                    count_next = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_next = SATURATE ? '0 : MAX_COUNT;
                    tc_next    = 1'b1;
                end else begin
                    count_next = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_next;
            tc_q       <= tc_next;
            load_err_q <= load_err_next;
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench: three counter variants (mod-12 wrap, mod-12 saturate,
// mod-16 wrap) share one stimulus stream and are checked against a reference model.
module tb_mod_n_updown_counter;

    logic clock;
    logic reset;

    int assertCount;
    int failCount;

    mod_n_updown_counter_if #(.WIDTH(4)) busWrap ();
    mod_n_updown_counter_if #(.WIDTH(4)) busSat ();
    mod_n_updown_counter_if #(.WIDTH(4)) busFull ();

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(1'b0)) dutWrap (
        .clock (clock),
        .reset (reset),
        .bus   (busWrap)
    );

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(1'b1)) dutSat (
        .clock (clock),
        .reset (reset),
        .bus   (busSat)
    );

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dutFull (
        .clock (clock),
        .reset (reset),
        .bus   (busFull)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0][3:0] count;
        logic [2:0]      tc;
        logic [2:0]      err;
    } expect_t;

    expect_t scoreboard[$];

    int modv[3]   = '{12, 12, 16};
    bit satv[3]   = '{1'b0, 1'b1, 1'b0};
    int mcount[3] = '{0, 0, 0};

    // Reference model: plain modular / clamped arithmetic on integers
    task automatic applyStimulus(input bit r, input bit l, input bit e, input bit u,
                                 input int d);
        expect_t ex;
        @(negedge clock);
        reset = r;
        busWrap.load = l;    busWrap.enable = e;    busWrap.upd = u;    busWrap.data_in = 4'(d);
        busSat.load = l;     busSat.enable = e;     busSat.upd = u;     busSat.data_in = 4'(d);
        busFull.load = l;    busFull.enable = e;    busFull.upd = u;    busFull.data_in = 4'(d);
        for (int i = 0; i < 3; i++) begin
            int c;
            bit t;
            bit er;
            c  = mcount[i];
            t  = 1'b0;
            er = 1'b0;
            if (r) begin
                c = 0;
            end else if (l) begin
                if (d < modv[i]) c = d;
                else er = 1'b1;
            end else if (e) begin
                if (u) begin
                    t = (c + 1 >= modv[i]);
                    c = satv[i] ? ((c + 1 > modv[i] - 1) ? modv[i] - 1 : c + 1)
                                : (c + 1) % modv[i];
                end else begin
                    t = (c == 0);
                    c = satv[i] ? ((c == 0) ? 0 : c - 1)
                                : (c + modv[i] - 1) % modv[i];
                end
            end
            mcount[i]    = c;
            ex.count[i]  = 4'(c);
            ex.tc[i]     = t;
            ex.err[i]    = er;
        end
        scoreboard.push_back(ex);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge
    initial begin
        expect_t ex;
        forever begin
            @(posedge clock);
            #1;
            if (scoreboard.size() > 0) begin
                ex = scoreboard.pop_front();
                checkOutput("wrap12.count", {28'b0, busWrap.count},    {28'b0, ex.count[0]});
                checkOutput("wrap12.tc",    {31'b0, busWrap.tc},       {31'b0, ex.tc[0]});
                checkOutput("wrap12.err",   {31'b0, busWrap.load_err}, {31'b0, ex.err[0]});
                checkOutput("sat12.count",  {28'b0, busSat.count},     {28'b0, ex.count[1]});
                checkOutput("sat12.tc",     {31'b0, busSat.tc},        {31'b0, ex.tc[1]});
                checkOutput("sat12.err",    {31'b0, busSat.load_err},  {31'b0, ex.err[1]});
                checkOutput("wrap16.count", {28'b0, busFull.count},    {28'b0, ex.count[2]});
                checkOutput("wrap16.tc",    {31'b0, busFull.tc},       {31'b0, ex.tc[2]});
                checkOutput("wrap16.err",   {31'b0, busFull.load_err}, {31'b0, ex.err[2]});
            end
        end
    end

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset = 1'b1;
        busWrap.load = 1'b0; busWrap.enable = 1'b0; busWrap.upd = 1'b0; busWrap.data_in = '0;
        busSat.load = 1'b0;  busSat.enable = 1'b0;  busSat.upd = 1'b0;  busSat.data_in = '0;
        busFull.load = 1'b0; busFull.enable = 1'b0; busFull.upd = 1'b0; busFull.data_in = '0;

        // Reset two cycles, then count up through the wrap
        repeat (2) applyStimulus(1, 0, 0, 0, 0);
        repeat (13) applyStimulus(0, 0, 1, 1, 0);

        // Load 3 and count down through the low wrap
        applyStimulus(0, 1, 0, 0, 3);
        repeat (5) applyStimulus(0, 0, 1, 0, 0);

        // Illegal loads hold the count and pulse load_err
        applyStimulus(0, 1, 1, 1, 5);
        applyStimulus(0, 1, 1, 0, 13);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 15);
        applyStimulus(0, 0, 0, 0, 0);

        // Top-end behaviour, then reverse direction
        applyStimulus(0, 1, 0, 0, 10);
        repeat (4) applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 0);

        // Reset together with load mid-count, then idle
        applyStimulus(0, 1, 0, 0, 6);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(1, 1, 1, 1, 2);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);

        // Full-range modulus: wrap at both ends
        applyStimulus(0, 1, 0, 0, 15);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);

        // Low-end saturation / wrap from zero
        applyStimulus(0, 1, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 1, 0, 0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 40) == 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 15)));
        end

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && scoreboard.size() > 0; w++) @(posedge clock);
        #2;
        assertCount++;
        if (scoreboard.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
